// File: rtl/l15_resp_pkg.sv
// Shared request/return encodings, transaction structs and byte-lane helpers
// for the L1.5 memory responder.
package l15_resp_pkg;

  localparam logic [4:0] LOAD_RQ   = 5'd0;
  localparam logic [4:0] STORE_RQ  = 5'd1;
  localparam logic [4:0] IMISS_RQ  = 5'd16;

  localparam logic [3:0] LOAD_RET  = 4'd0;
  localparam logic [3:0] IFILL_RET = 4'd1;
  localparam logic [3:0] ST_ACK    = 4'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0]  rqtype;
    logic        nc;
    logic [2:0]  size;
    logic [39:0] address;
    logic [63:0] data;
  } l15_req_t;

  typedef struct packed {
    logic [3:0] rtype;
    logic       nc;
  } l15_rtrn_t;

  function automatic logic [63:0] bswap64(input logic [63:0] d);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) begin
      r[8*k +: 8] = d[56-8*k +: 8];
    end
    return r;
  endfunction

  // Byte enables in RAM (little-endian) lane order; offset is aligned down to the size.
  function automatic logic [7:0] size_to_bemask(input logic [2:0] size, input logic [2:0] off);
    logic [7:0] m;
    case (size)
      3'd0:    m = 8'h01 << off;
      3'd1:    m = 8'h03 << {off[2:1], 1'b0};
      3'd2:    m = 8'h0f << {off[2], 2'b00};
      default: m = 8'hff;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/l15_resp_ram.sv
// Single-port 64-bit backing RAM with byte enables and one-cycle registered read.
// Contents are deliberately not reset.
module l15_resp_ram #(
  parameter int unsigned WORDS = 4096,
  localparam int unsigned AW   = $clog2(WORDS)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    be_i,
  input  logic [63:0]   wdata_i,
  output logic [63:0]   rdata_o
);

  logic [63:0] mem [WORDS];

  // Byte-masked write and registered read on the same port.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int k = 0; k < 8; k++) begin
          if (be_i[k]) begin
            mem[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
          end
        end
      end
      rdata_o <= mem[addr_i];
    end
  end

endmodule

// File: rtl/l15_mem_responder.sv
// L1.5 request/return responder backed by an internal RAM with programmable latency.
// Optional request counters: define L15_MEM_RESPONDER_STATS_EN.
module l15_mem_responder #(
  parameter int unsigned LINE_WIDTH = 128,
  parameter int unsigned TID_WIDTH  = 2,
  parameter int unsigned MEM_WORDS  = 4096,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_val_i,
  input  logic [4:0]            req_rqtype_i,
  input  logic                  req_nc_i,
  input  logic [2:0]            req_size_i,
  input  logic [TID_WIDTH-1:0]  req_threadid_i,
  input  logic [39:0]           req_address_i,
  input  logic [63:0]           req_data_i,
  output logic                  req_ack_o,
  output logic                  rtrn_val_o,
  output logic [3:0]            rtrn_returntype_o,
  output logic [TID_WIDTH-1:0]  rtrn_threadid_o,
  output logic                  rtrn_nc_o,
  output logic [LINE_WIDTH-1:0] rtrn_data_o,
  input  logic                  rtrn_ack_i
`ifdef L15_MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0]           stat_loads_o,
  output logic [31:0]           stat_stores_o,
  output logic [31:0]           stat_ifills_o
`endif
);
  import l15_resp_pkg::*;

  localparam int unsigned NBEATS = LINE_WIDTH / 64;
  localparam int unsigned AW     = $clog2(MEM_WORDS);

  state_t               state, state_nxt;
  l15_req_t             req;
  logic [TID_WIDTH-1:0] tid;
  logic [7:0]           cnt;
  logic [2:0]           issued, nreads;
  logic                 rd_pend;
  logic [1:0]           rd_beat;
  logic                 accept, is_load, is_store, is_fill;
  logic                 rd_issue, wr_fire, done, ram_en;
  logic [AW-1:0]        idx, line_base, ram_addr;
  logic [63:0]          ram_rdata;
  l15_rtrn_t            rtrn_next;
  logic                 unused_bits;

  assign accept      = (state == S_IDLE) && req_val_i && !rst_i;
  assign req_ack_o   = accept;
  assign is_load     = (req.rqtype == LOAD_RQ);
  assign is_store    = (req.rqtype == STORE_RQ);
  assign is_fill     = (req.rqtype == IMISS_RQ);
  assign idx         = req.address[3 +: AW];
  assign line_base   = idx & ~AW'(NBEATS - 1);
  assign unused_bits = ^req.address[39:3+AW];

  // Decode the captured request into read beats, RAM control and return fields.
  always_comb begin
    nreads          = 3'd0;
    rtrn_next.rtype = ST_ACK;
    rtrn_next.nc    = req.nc;
    if (is_fill) begin
      nreads          = 3'(NBEATS);
      rtrn_next.rtype = IFILL_RET;
    end else if (is_load) begin
      nreads          = req.nc ? 3'd1 : 3'(NBEATS);
      rtrn_next.rtype = LOAD_RET;
    end else begin
      nreads          = 3'd0;
      rtrn_next.rtype = ST_ACK;
    end
    // Reads may run ahead of the countdown; the store write waits for it to expire.
    rd_issue = (state == S_WAIT) && (issued < nreads);
    wr_fire  = (state == S_WAIT) && is_store && (cnt == 8'd0) && !rst_i;
    done     = (state == S_WAIT) && (cnt == 8'd0) && (issued == nreads);
    ram_en   = rd_issue || wr_fire;
    if (wr_fire || (is_load && req.nc)) begin
      ram_addr = idx;
    end else begin
      ram_addr = line_base + AW'(issued);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = accept ? S_WAIT : S_IDLE;
      S_WAIT:  state_nxt = done ? S_RESP : S_WAIT;
      S_RESP:  state_nxt = rtrn_ack_i ? S_IDLE : S_RESP;
      default: state_nxt = S_IDLE;
    endcase
  end

  l15_resp_ram #(.WORDS(MEM_WORDS)) u_ram (
    .clk_i   (clk_i),
    .en_i    (ram_en),
    .we_i    (wr_fire),
    .addr_i  (ram_addr),
    .be_i    (size_to_bemask(req.size, req.address[2:0])),
    .wdata_i (bswap64(req.data)),
    .rdata_o (ram_rdata)
  );

  // State, capture, read sequencing and registered return channel.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= S_IDLE;
      req               <= '0;
      tid               <= '0;
      cnt               <= 8'd0;
      issued            <= 3'd0;
      rd_pend           <= 1'b0;
      rd_beat           <= 2'd0;
      rtrn_val_o        <= 1'b0;
      rtrn_returntype_o <= 4'd0;
      rtrn_threadid_o   <= '0;
      rtrn_nc_o         <= 1'b0;
      rtrn_data_o       <= '0;
    end else begin
      state   <= state_nxt;
      rd_pend <= rd_issue;
      rd_beat <= issued[1:0];
      if (rd_pend) begin
        rtrn_data_o[int'(rd_beat)*64 +: 64] <= bswap64(ram_rdata);
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            req         <= '{rqtype: req_rqtype_i, nc: req_nc_i, size: req_size_i,
                             address: req_address_i, data: req_data_i};
            tid         <= req_threadid_i;
            cnt         <= 8'(LATENCY - 1);
            issued      <= 3'd0;
            rtrn_data_o <= '0;
          end
        end
        S_WAIT: begin
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          if (rd_issue) issued <= issued + 3'd1;
          if (done) begin
            rtrn_val_o        <= 1'b1;
            rtrn_returntype_o <= rtrn_next.rtype;
            rtrn_nc_o         <= rtrn_next.nc;
            rtrn_threadid_o   <= tid;
          end
        end
        S_RESP: begin
          if (rtrn_ack_i) rtrn_val_o <= 1'b0;
        end
        default: rtrn_val_o <= 1'b0;
      endcase
    end
  end

`ifdef L15_MEM_RESPONDER_STATS_EN
  // Saturating per-type counters of accepted requests.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_loads_o  <= 32'd0;
      stat_stores_o <= 32'd0;
      stat_ifills_o <= 32'd0;
    end else if (accept) begin
      if (req_rqtype_i == LOAD_RQ && stat_loads_o != 32'hffff_ffff)
        stat_loads_o <= stat_loads_o + 32'd1;
      if (req_rqtype_i == STORE_RQ && stat_stores_o != 32'hffff_ffff)
        stat_stores_o <= stat_stores_o + 32'd1;
      if (req_rqtype_i == IMISS_RQ && stat_ifills_o != 32'hffff_ffff)
        stat_ifills_o <= stat_ifills_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l15_mem_responder.sv
// Self-checking bench for l15_mem_responder: directed scenarios plus randomized
// traffic checked against a byte-addressed memory model.
module tb_l15_mem_responder;

  localparam int LW  = 128;
  localparam int TW  = 2;
  localparam int MW  = 4096;
  localparam int LAT = 4;
  localparam logic [4:0] RQ_LOAD  = 5'd0;
  localparam logic [4:0] RQ_STORE = 5'd1;
  localparam logic [4:0] RQ_IMISS = 5'd16;

  logic          clk_i = 1'b0;
  logic          rst_i, req_val_i, req_nc_i, rtrn_ack_i;
  logic [4:0]    req_rqtype_i;
  logic [2:0]    req_size_i;
  logic [TW-1:0] req_threadid_i, rtrn_threadid_o;
  logic [39:0]   req_address_i;
  logic [63:0]   req_data_i;
  logic          req_ack_o, rtrn_val_o, rtrn_nc_o;
  logic [3:0]    rtrn_returntype_o;
  logic [LW-1:0] rtrn_data_o;

  int total = 0;
  int bad   = 0;
  logic [7:0] mref [0:MW*8-1];

  always #5 clk_i = ~clk_i;

  l15_mem_responder #(.LINE_WIDTH(LW), .TID_WIDTH(TW), .MEM_WORDS(MW), .LATENCY(LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_val_i(req_val_i), .req_rqtype_i(req_rqtype_i),
    .req_nc_i(req_nc_i), .req_size_i(req_size_i), .req_threadid_i(req_threadid_i),
    .req_address_i(req_address_i), .req_data_i(req_data_i), .req_ack_o(req_ack_o),
    .rtrn_val_o(rtrn_val_o), .rtrn_returntype_o(rtrn_returntype_o),
    .rtrn_threadid_o(rtrn_threadid_o), .rtrn_nc_o(rtrn_nc_o), .rtrn_data_o(rtrn_data_o),
    .rtrn_ack_i(rtrn_ack_i)
  );

  function automatic int bidx(input logic [39:0] a);
    return int'(a % 40'(MW*8));
  endfunction

  // Interface word: byte offset k sits at bits [63-8k -: 8].
  function automatic logic [63:0] ref_word(input logic [39:0] a);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[63-8*k -: 8] = mref[bidx({a[39:3], 3'b000} + 40'(k))];
    return w;
  endfunction

  function automatic logic [LW-1:0] ref_line(input logic [39:0] a);
    logic [LW-1:0] l;
    logic [39:0]   base;
    base = a & ~40'(LW/8 - 1);
    for (int i = 0; i < LW/64; i++) l[64*i +: 64] = ref_word(base + 40'(8*i));
    return l;
  endfunction

  function automatic void ref_store(input logic [39:0] a, input logic [2:0] sz, input logic [63:0] d);
    int n, off;
    n   = (sz >= 3'd3) ? 8 : (1 << sz);
    off = int'(a[2:0]) & ~(n - 1);
    for (int k = off; k < off + n; k++) mref[bidx({a[39:3], 3'b000} + 40'(k))] = d[63-8*k -: 8];
  endfunction

  function automatic logic [LW-1:0] exp_data(input logic [4:0] rq, input logic nc, input logic [39:0] a);
    if (rq == RQ_IMISS || (rq == RQ_LOAD && !nc)) return ref_line(a);
    else if (rq == RQ_LOAD) return {{(LW-64){1'b0}}, ref_word(a)};
    else return '0;
  endfunction

  function automatic logic [3:0] exp_rt(input logic [4:0] rq);
    if (rq == RQ_LOAD) return 4'd0;
    else if (rq == RQ_IMISS) return 4'd1;
    else return 4'd4;
  endfunction

  // Drive one request, wait for its return, consume it. ok=0 on timeout.
  task automatic transact(input logic [4:0] rq, input logic nc, input logic [2:0] sz,
                          input logic [TW-1:0] id, input logic [39:0] a, input logic [63:0] d,
                          output logic ok, output int wait_n, output int lat,
                          output logic [3:0] rt, output logic [LW-1:0] rdat,
                          output logic [TW-1:0] rid, output logic rnc);
    ok = 1'b1; wait_n = 0; lat = 0; rt = '0; rdat = '0; rid = '0; rnc = 1'b0;
    @(posedge clk_i); #1;
    req_rqtype_i = rq; req_nc_i = nc; req_size_i = sz; req_threadid_i = id;
    req_address_i = a; req_data_i = d; req_val_i = 1'b1;
    @(negedge clk_i);
    while (!req_ack_o && wait_n < 50) begin wait_n++; @(negedge clk_i); end
    if (!req_ack_o) begin ok = 1'b0; req_val_i = 1'b0; return; end
    @(posedge clk_i); #1;
    req_val_i = 1'b0;
    @(negedge clk_i); lat = 1;
    while (!rtrn_val_o && lat < 300) begin lat++; @(negedge clk_i); end
    if (!rtrn_val_o) begin ok = 1'b0; return; end
    rt = rtrn_returntype_o; rdat = rtrn_data_o; rid = rtrn_threadid_o; rnc = rtrn_nc_o;
    rtrn_ack_i = 1'b1;
    @(posedge clk_i); #1;
    rtrn_ack_i = 1'b0;
  endtask

  logic          ok, rnc;
  int            wn, lat;
  logic [3:0]    rt;
  logic [LW-1:0] rdat;
  logic [TW-1:0] rid;

  task automatic test_reset();
    rst_i = 1'b1; req_val_i = 1'b0; rtrn_ack_i = 1'b0;
    req_rqtype_i = '0; req_nc_i = 1'b0; req_size_i = '0; req_threadid_i = '0;
    req_address_i = '0; req_data_i = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    total++;
    if (rtrn_val_o !== 1'b0 || req_ack_o !== 1'b0) begin
      bad++; $display("FAIL reset_ctl val=%b ack=%b want 0 0", rtrn_val_o, req_ack_o);
    end
    total++;
    if ({rtrn_returntype_o, rtrn_threadid_o, rtrn_nc_o} !== '0 || rtrn_data_o !== '0) begin
      bad++; $display("FAIL reset_fields rt=%h tid=%h nc=%b data=%h want 0", rtrn_returntype_o,
                      rtrn_threadid_o, rtrn_nc_o, rtrn_data_o);
    end
  endtask

  task automatic test_prefill();
    logic [63:0] d;
    for (int w = 0; w < 64; w++) begin
      d = {$urandom, $urandom};
      transact(RQ_STORE, 1'b0, 3'd3, TW'(w), 40'(w*8), d, ok, wn, lat, rt, rdat, rid, rnc);
      ref_store(40'(w*8), 3'd3, d);
      total++;
      if ({ok, rt, rid} !== {1'b1, 4'd4, TW'(w)}) begin
        bad++; $display("FAIL prefill w=%0d ok=%b rt=%h tid=%h want 1 4 %h", w, ok, rt, rid, TW'(w));
      end
    end
  endtask

  task automatic test_store_nc_load();
    transact(RQ_STORE, 1'b0, 3'd3, 2'd2, 40'h80, 64'h0011223344556677, ok, wn, lat, rt, rdat, rid, rnc);
    ref_store(40'h80, 3'd3, 64'h0011223344556677);
    total++;
    if ({ok, rt, rid} !== {1'b1, 4'd4, 2'd2}) begin
      bad++; $display("FAIL st8_ack ok=%b rt=%h tid=%h want 1 4 2", ok, rt, rid);
    end
    transact(RQ_LOAD, 1'b1, 3'd3, 2'd1, 40'h80, 64'h0, ok, wn, lat, rt, rdat, rid, rnc);
    total++;
    if ({ok, rt, rid, rnc} !== {1'b1, 4'd0, 2'd1, 1'b1}) begin
      bad++; $display("FAIL ncld_hdr ok=%b rt=%h tid=%h nc=%b want 1 0 1 1", ok, rt, rid, rnc);
    end
    total++;
    if (rdat !== {64'h0, 64'h0011223344556677}) begin
      bad++; $display("FAIL ncld_data got=%h want=%h", rdat, {64'h0, 64'h0011223344556677});
    end
  endtask

  task automatic test_byte_store();
    transact(RQ_STORE, 1'b0, 3'd0, 2'd0, 40'h83, 64'h000000ab00000000, ok, wn, lat, rt, rdat, rid, rnc);
    ref_store(40'h83, 3'd0, 64'h000000ab00000000);
    total++;
    if ({ok, rt} !== {1'b1, 4'd4}) begin
      bad++; $display("FAIL st1_ack ok=%b rt=%h want 1 4", ok, rt);
    end
    transact(RQ_LOAD, 1'b0, 3'd3, 2'd3, 40'h80, 64'h0, ok, wn, lat, rt, rdat, rid, rnc);
    total++;
    if (rdat !== ref_line(40'h80) || rdat[39:32] !== 8'hab) begin
      bad++; $display("FAIL st1_line got=%h want=%h", rdat, ref_line(40'h80));
    end
  endtask

  task automatic test_ifill_latency();
    transact(RQ_IMISS, 1'b0, 3'd3, 2'd0, 40'h100, 64'h0, ok, wn, lat, rt, rdat, rid, rnc);
    total++;
    if ({ok, rt} !== {1'b1, 4'd1} || wn !== 0 || lat !== LAT + 1) begin
      bad++; $display("FAIL ifill_timing ok=%b rt=%h ackwait=%0d lat=%0d want 1 1 0 %0d", ok, rt, wn, lat, LAT + 1);
    end
    total++;
    if (rdat !== ref_line(40'h100)) begin
      bad++; $display("FAIL ifill_data got=%h want=%h", rdat, ref_line(40'h100));
    end
  endtask

  task automatic test_hold();
    logic [LW-1:0] first;
    int n;
    @(posedge clk_i); #1;
    req_rqtype_i = RQ_LOAD; req_nc_i = 1'b0; req_size_i = 3'd3; req_threadid_i = 2'd2;
    req_address_i = 40'h80; req_data_i = 64'h0; req_val_i = 1'b1;
    @(negedge clk_i);
    total++;
    if (req_ack_o !== 1'b1) begin bad++; $display("FAIL hold_accept ack=%b want 1", req_ack_o); end
    @(posedge clk_i); #1;
    req_nc_i = 1'b1; req_threadid_i = 2'd1; req_address_i = 40'h88;
    n = 0;
    @(negedge clk_i);
    while (!rtrn_val_o && n < 50) begin n++; @(negedge clk_i); end
    total++;
    if (rtrn_val_o !== 1'b1 || rtrn_data_o !== ref_line(40'h80) || rtrn_threadid_o !== 2'd2) begin
      bad++; $display("FAIL hold_first val=%b data=%h tid=%h want 1 %h 2", rtrn_val_o, rtrn_data_o,
                      rtrn_threadid_o, ref_line(40'h80));
      req_val_i = 1'b0; return;
    end
    first = rtrn_data_o;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      total++;
      if (rtrn_val_o !== 1'b1 || req_ack_o !== 1'b0 || rtrn_data_o !== first) begin
        bad++; $display("FAIL hold_stable cyc=%0d val=%b ack=%b data=%h want 1 0 %h", i, rtrn_val_o,
                        req_ack_o, rtrn_data_o, first);
      end
    end
    rtrn_ack_i = 1'b1;
    total++;
    if (req_ack_o !== 1'b0) begin bad++; $display("FAIL hold_ackcyc ack=%b want 0", req_ack_o); end
    @(posedge clk_i); #1;
    rtrn_ack_i = 1'b0;
    @(negedge clk_i);
    total++;
    if (req_ack_o !== 1'b1 || rtrn_val_o !== 1'b0) begin
      bad++; $display("FAIL hold_second_accept ack=%b val=%b want 1 0", req_ack_o, rtrn_val_o);
    end
    @(posedge clk_i); #1;
    req_val_i = 1'b0;
    n = 0;
    @(negedge clk_i);
    while (!rtrn_val_o && n < 50) begin n++; @(negedge clk_i); end
    total++;
    if (rtrn_val_o !== 1'b1 || rtrn_data_o !== {64'h0, ref_word(40'h88)} ||
        rtrn_threadid_o !== 2'd1 || rtrn_nc_o !== 1'b1) begin
      bad++; $display("FAIL hold_second val=%b data=%h tid=%h nc=%b want 1 %h 1 1", rtrn_val_o,
                      rtrn_data_o, rtrn_threadid_o, rtrn_nc_o, {64'h0, ref_word(40'h88)});
    end
    rtrn_ack_i = 1'b1;
    @(posedge clk_i); #1;
    rtrn_ack_i = 1'b0;
  endtask

  task automatic test_alias();
    logic [63:0] d;
    d = {$urandom, $urandom};
    transact(RQ_STORE, 1'b0, 3'd3, 2'd1, 40'h80 + 40'(MW*8), d, ok, wn, lat, rt, rdat, rid, rnc);
    ref_store(40'h80 + 40'(MW*8), 3'd3, d);
    transact(RQ_LOAD, 1'b1, 3'd3, 2'd0, 40'h80, 64'h0, ok, wn, lat, rt, rdat, rid, rnc);
    total++;
    if (ok !== 1'b1 || rdat !== {64'h0, d}) begin
      bad++; $display("FAIL alias ok=%b got=%h want=%h", ok, rdat, {64'h0, d});
    end
  endtask

  task automatic test_unsupported();
    transact(5'd2, 1'b0, 3'd3, 2'd3, 40'h80, {$urandom, $urandom}, ok, wn, lat, rt, rdat, rid, rnc);
    total++;
    if ({ok, rt, rid} !== {1'b1, 4'd4, 2'd3} || rdat !== '0) begin
      bad++; $display("FAIL unsup ok=%b rt=%h tid=%h data=%h want 1 4 3 0", ok, rt, rid, rdat);
    end
    transact(RQ_LOAD, 1'b1, 3'd3, 2'd0, 40'h80, 64'h0, ok, wn, lat, rt, rdat, rid, rnc);
    total++;
    if (rdat !== {64'h0, ref_word(40'h80)}) begin
      bad++; $display("FAIL unsup_nowrite got=%h want=%h", rdat, {64'h0, ref_word(40'h80)});
    end
  endtask

  task automatic test_random();
    logic [4:0] rq; logic nc; logic [2:0] sz; logic [TW-1:0] id;
    logic [39:0] a; logic [63:0] d; logic [31:0] hi;
    logic [LW-1:0] ed; logic [3:0] ert;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 2))
        0: rq = RQ_LOAD;
        1: rq = RQ_STORE;
        default: rq = RQ_IMISS;
      endcase
      nc = 1'($urandom_range(0, 1)); sz = 3'($urandom_range(0, 7)); id = TW'($urandom_range(0, 3));
      hi = $urandom; d = {$urandom, $urandom};
      a  = {hi[24:0], 6'd0, 6'($urandom_range(0, 63)), 3'($urandom_range(0, 7))};
      ed = exp_data(rq, nc, a); ert = exp_rt(rq);
      transact(rq, nc, sz, id, a, d, ok, wn, lat, rt, rdat, rid, rnc);
      if (rq == RQ_STORE) ref_store(a, sz, d);
      total++;
      if ({ok, rt, rid, rnc} !== {1'b1, ert, id, nc} || lat !== LAT + 1) begin
        bad++; $display("FAIL rand_hdr it=%0d ok=%b rt=%h tid=%h nc=%b lat=%0d want 1 %h %h %b %0d",
                        it, ok, rt, rid, rnc, lat, ert, id, nc, LAT + 1);
      end
      if (rq != RQ_STORE) begin
        total++;
        if (rdat !== ed) begin
          bad++; $display("FAIL rand_data it=%0d a=%h got=%h want=%h", it, a, rdat, ed);
        end
      end
    end
  endtask

  task automatic test_reset_wait();
    int n;
    @(posedge clk_i); #1;
    req_rqtype_i = RQ_STORE; req_nc_i = 1'b0; req_size_i = 3'd3; req_threadid_i = 2'd1;
    req_address_i = 40'h90; req_data_i = ~ref_word(40'h90); req_val_i = 1'b1;
    @(negedge clk_i);
    total++;
    if (req_ack_o !== 1'b1) begin bad++; $display("FAIL rstw_accept ack=%b want 1", req_ack_o); end
    @(posedge clk_i); #1;
    req_val_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    req_rqtype_i = RQ_LOAD; req_nc_i = 1'b1; req_threadid_i = 2'd2; req_val_i = 1'b1;
    @(negedge clk_i);
    total++;
    if (rtrn_val_o !== 1'b0 || rtrn_data_o !== '0 || rtrn_returntype_o !== 4'd0 || req_ack_o !== 1'b1) begin
      bad++; $display("FAIL rstw_after val=%b data=%h rt=%h ack=%b want 0 0 0 1", rtrn_val_o,
                      rtrn_data_o, rtrn_returntype_o, req_ack_o);
    end
    @(posedge clk_i); #1;
    req_val_i = 1'b0;
    n = 1;
    @(negedge clk_i);
    while (!rtrn_val_o && n < 50) begin n++; @(negedge clk_i); end
    total++;
    if (n !== LAT + 1 || rtrn_data_o !== {64'h0, ref_word(40'h90)} || rtrn_threadid_o !== 2'd2) begin
      bad++; $display("FAIL rstw_load lat=%0d data=%h tid=%h want %0d %h 2", n, rtrn_data_o,
                      rtrn_threadid_o, LAT + 1, {64'h0, ref_word(40'h90)});
    end
    rtrn_ack_i = 1'b1;
    @(posedge clk_i); #1;
    rtrn_ack_i = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_prefill();
    test_store_nc_load();
    test_byte_store();
    test_ifill_latency();
    test_hold();
    test_alias();
    test_unsupported();
    test_random();
    test_reset_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
